// File: rtl/rmii_rx.sv
// rmii_rx: receive half of the 100 Mb/s RMII MAC -- preamble/SFD strip, dibit-to-byte assembly, frame status.
// Optional FCS residue check is compiled in when RMII_RX_FCS_CHECK_EN is defined.
module rmii_rx #(
  parameter int MAX_LEN = 1522
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        crs_dv,
  input  logic [1:0]  rxd,
  output logic        wr_en,
  output logic [15:0] wr_idx,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic [15:0] frame_len,
  output logic        done,
  output logic        err
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  localparam logic [15:0] LEN_LIMIT = 16'(MAX_LEN);

  logic [1:0]  state;
  logic [5:0]  shift_reg;
  logic [1:0]  pair;
  logic [15:0] count;
  logic        low_seen;
  logic        overflow;
  logic [7:0]  assembled;
  logic        frame_start;
  logic        frame_end;
  logic        byte_done;
  logic        crc_bad;

  // Dibits arrive LSB first, so the dibit on the wire completes the top of the byte.
  assign assembled   = {rxd, shift_reg};
  assign frame_start = (state == S_PREAMBLE) && crs_dv && (rxd == 2'b11);
  assign frame_end   = (state == S_DATA) && !crs_dv && low_seen;
  assign byte_done   = (state == S_DATA) && !frame_end && (pair == 2'd3) && (count != LEN_LIMIT);

`ifdef RMII_RX_FCS_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Running over data plus FCS leaves the fixed CRC-32 residue when the frame is intact.
  always_ff @(posedge clk50) begin
    if (rst || frame_start) begin
      crc <= 32'hFFFFFFFF;
    end else if (byte_done) begin
      crc <= crc_byte(crc, assembled);
    end
  end

  assign crc_bad = (crc != 32'hDEBB20E3);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk50) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      pair      <= '0;
      count     <= '0;
      low_seen  <= 1'b0;
      overflow  <= 1'b0;
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      data_out  <= '0;
      busy      <= 1'b0;
      frame_len <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          low_seen <= 1'b0;
          if (crs_dv) begin
            if (rxd == 2'b01) begin
              state <= S_PREAMBLE;
            end else if (rxd != 2'b00) begin
              state <= S_DROP;
            end
          end
        end
        S_PREAMBLE: begin
          if (frame_start) begin
            state    <= S_DATA;
            busy     <= 1'b1;
            pair     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            low_seen <= 1'b0;
          end else if (!crs_dv || rxd != 2'b01) begin
            state    <= S_DROP;
            low_seen <= !crs_dv;
          end
        end
        S_DATA: begin
          if (frame_end) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            low_seen  <= 1'b0;
            frame_len <= count;
            if ((count == 16'd0) || overflow || crc_bad) begin
              err <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            // A lone low cycle is CRS_DV toggling; its dibit is still data.
            low_seen  <= !crs_dv;
            shift_reg <= assembled[7:2];
            pair      <= pair + 2'd1;
            if (byte_done) begin
              wr_en    <= 1'b1;
              data_out <= assembled;
              wr_idx   <= count;
              count    <= count + 16'd1;
            end else if (pair == 2'd3) begin
              overflow <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!crs_dv) begin
            if (low_seen) begin
              state    <= S_IDLE;
              low_seen <= 1'b0;
            end else begin
              low_seen <= 1'b1;
            end
          end else begin
            low_seen <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rmii_rx.sv
// tb_rmii_rx: randomized self-checking bench for rmii_rx against a frame-level reference model.
// A second instance with MAX_LEN=4 exercises the overflow path.
`timescale 1ns/1ps
module tb_rmii_rx;
  typedef struct packed {logic [15:0] idx; logic [7:0] data;} wr_t;
  typedef struct packed {logic is_err; logic [15:0] len;} end_t;

`ifdef RMII_RX_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic        clk50 = 1'b0;
  logic        rst;
  logic        crs_dv;
  logic [1:0]  rxd;
  logic        wr_en, busy, done, err;
  logic [15:0] wr_idx, frame_len;
  logic [7:0]  data_out;
  logic        s_wr_en, s_busy, s_done, s_err;
  logic [15:0] s_wr_idx, s_frame_len;
  logic [7:0]  s_data_out;

  int total = 0;
  int bad = 0;

  logic [7:0] tx_q[$];
  wr_t  wr_q[$], s_wr_q[$], exp_wr_q[$];
  end_t end_q[$], s_end_q[$], exp_end_q[$];
  int   overlap_cnt;
  bit   busy_seen;

  rmii_rx dut (
    .clk50(clk50), .rst(rst), .crs_dv(crs_dv), .rxd(rxd),
    .wr_en(wr_en), .wr_idx(wr_idx), .data_out(data_out), .busy(busy),
    .frame_len(frame_len), .done(done), .err(err)
  );

  rmii_rx #(.MAX_LEN(4)) dut_small (
    .clk50(clk50), .rst(rst), .crs_dv(crs_dv), .rxd(rxd),
    .wr_en(s_wr_en), .wr_idx(s_wr_idx), .data_out(s_data_out), .busy(s_busy),
    .frame_len(s_frame_len), .done(s_done), .err(s_err)
  );

  always #10 clk50 = ~clk50;

  // Outputs are collected on the falling edge, half a cycle after they change.
  always @(negedge clk50) begin
    if (wr_en === 1'b1) wr_q.push_back({wr_idx, data_out});
    if (done === 1'b1 || err === 1'b1) end_q.push_back({err, frame_len});
    if (wr_en === 1'b1 && (done === 1'b1 || err === 1'b1)) overlap_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (s_wr_en === 1'b1) s_wr_q.push_back({s_wr_idx, s_data_out});
    if (s_done === 1'b1 || s_err === 1'b1) s_end_q.push_back({s_err, s_frame_len});
  end

  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, tx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic append_fcs();
    logic [31:0] f;
    f = ~crc32(tx_q.size());
    for (int i = 0; i < 4; i++) tx_q.push_back(f[8*i +: 8]);
  endtask

  function automatic bit fcs_good();
    int n;
    n = tx_q.size();
    if (n < 4) return 1'b0;
    return ~crc32(n - 4) == {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]};
  endfunction

  // Reference: bytes up to the limit are written in order; the end status follows length and FCS rules.
  task automatic model_frame(input int max_len);
    int   n;
    wr_t  w;
    end_t e;
    n = tx_q.size();
    for (int i = 0; i < n && i < max_len; i++) begin
      w = {16'(i), tx_q[i]};
      exp_wr_q.push_back(w);
    end
    e.is_err = (n == 0) || (n > max_len) || (FCS_EN && !fcs_good());
    e.len    = 16'((n > max_len) ? max_len : n);
    exp_end_q.push_back(e);
  endtask

  task automatic clear_monitor();
    wr_q.delete(); s_wr_q.delete(); end_q.delete(); s_end_q.delete();
    exp_wr_q.delete(); exp_end_q.delete();
    overlap_cnt = 0;
    busy_seen   = 1'b0;
  endtask

  task automatic dibit(input logic cv, input logic [1:0] d);
    @(negedge clk50);
    crs_dv = cv;
    rxd    = d;
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 31; i++) dibit(1'b1, 2'b01);
    dibit(1'b1, 2'b11);
  endtask

  task automatic send_frame(input int toggle_at, input int partial, input int gap);
    logic [7:0] b;
    send_preamble();
    for (int i = 0; i < tx_q.size(); i++) begin
      b = tx_q[i];
      for (int j = 0; j < 4; j++) dibit(((i * 4 + j) == toggle_at) ? 1'b0 : 1'b1, b[2*j +: 2]);
    end
    for (int k = 0; k < partial; k++) dibit(1'b1, 2'($urandom));
    dibit(1'b0, 2'($urandom));
    dibit(1'b0, 2'($urandom));
    repeat (gap) dibit(1'b0, 2'b00);
  endtask

  task automatic fill_random(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1; crs_dv = 1'b0; rxd = 2'b00;
    repeat (3) @(negedge clk50);
    total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    total++; if (frame_len !== 16'd0) begin bad++; $display("[TB] FAIL reset_frame_len got=%0d exp=0", frame_len); end
    total++; if (wr_idx !== 16'd0 || data_out !== 8'd0) begin bad++; $display("[TB] FAIL reset_wr_bus got=%h/%h exp=0/0", wr_idx, data_out); end
    rst = 1'b0;
    repeat (2) @(negedge clk50);
  endtask

  task automatic test_basic(input int toggle_at, input string tag);
    logic [7:0] exp_data [3];
    exp_data = '{8'h12, 8'h34, 8'hAB};
    clear_monitor();
    tx_q = '{8'h12, 8'h34, 8'hAB};
    send_frame(toggle_at, 0, 4);
    total++; if (wr_q.size() != 3) begin bad++; $display("[TB] FAIL %s_wr_count got=%0d exp=3", tag, wr_q.size()); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i].idx !== 16'(i) || wr_q[i].data !== exp_data[i]) begin
        bad++; $display("[TB] FAIL %s_wr[%0d] got=%0d/%h exp=%0d/%h", tag, i, wr_q[i].idx, wr_q[i].data, i, exp_data[i]);
      end
    end
    total++; if (end_q.size() != 1) begin bad++; $display("[TB] FAIL %s_end_count got=%0d exp=1", tag, end_q.size()); end
    else begin
      total++; if (end_q[0].is_err !== FCS_EN) begin bad++; $display("[TB] FAIL %s_status got err=%b exp err=%b", tag, end_q[0].is_err, FCS_EN); end
      total++; if (end_q[0].len !== 16'd3) begin bad++; $display("[TB] FAIL %s_frame_len got=%0d exp=3", tag, end_q[0].len); end
    end
    total++; if (!busy_seen || busy !== 1'b0) begin bad++; $display("[TB] FAIL %s_busy got seen=%b now=%b exp seen=1 now=0", tag, busy_seen, busy); end
    total++; if (overlap_cnt != 0) begin bad++; $display("[TB] FAIL %s_overlap got=%0d exp=0", tag, overlap_cnt); end
  endtask

  task automatic test_bad_preamble();
    clear_monitor();
    for (int i = 0; i < 20; i++) dibit(1'b1, 2'b01);
    dibit(1'b1, 2'b10);
    for (int i = 0; i < 11; i++) dibit(1'b1, 2'b01);
    dibit(1'b1, 2'b11);
    for (int i = 0; i < 12; i++) dibit(1'b1, 2'($urandom));
    repeat (4) dibit(1'b0, 2'b00);
    total++; if (wr_q.size() != 0 || end_q.size() != 0) begin bad++; $display("[TB] FAIL badpre_quiet got wr=%0d end=%0d exp 0/0", wr_q.size(), end_q.size()); end
    fill_random(5);
    model_frame(1522);
    send_frame(-1, 1, 4);
    total++; if (wr_q.size() != exp_wr_q.size()) begin bad++; $display("[TB] FAIL badpre_wr_count got=%0d exp=%0d", wr_q.size(), exp_wr_q.size()); end
    foreach (exp_wr_q[i]) if (i < wr_q.size()) begin total++; if (wr_q[i] !== exp_wr_q[i]) begin bad++; $display("[TB] FAIL badpre_wr[%0d] got=%h exp=%h", i, wr_q[i], exp_wr_q[i]); end end
    total++; if (end_q.size() != 1 || end_q[0] !== exp_end_q[0]) begin bad++; $display("[TB] FAIL badpre_end got n=%0d first=%h exp n=1 first=%h", end_q.size(), (end_q.size() > 0) ? end_q[0] : 17'h0, exp_end_q[0]); end
  endtask

  task automatic test_overflow();
    clear_monitor();
    fill_random(6);
    model_frame(1522);
    send_frame(-1, 0, 4);
    total++; if (s_wr_q.size() != 4) begin bad++; $display("[TB] FAIL ovf_wr_count got=%0d exp=4", s_wr_q.size()); end
    for (int i = 0; i < 4 && i < s_wr_q.size(); i++) begin
      total++;
      if (s_wr_q[i].idx !== 16'(i) || s_wr_q[i].data !== tx_q[i]) begin
        bad++; $display("[TB] FAIL ovf_wr[%0d] got=%0d/%h exp=%0d/%h", i, s_wr_q[i].idx, s_wr_q[i].data, i, tx_q[i]);
      end
    end
    total++; if (s_end_q.size() != 1 || s_end_q[0] !== {1'b1, 16'd4}) begin bad++; $display("[TB] FAIL ovf_end got n=%0d first=%h exp n=1 err=1 len=4", s_end_q.size(), (s_end_q.size() > 0) ? s_end_q[0] : 17'h0); end
    total++; if (wr_q.size() != 6 || end_q.size() != 1 || end_q[0] !== exp_end_q[0]) begin bad++; $display("[TB] FAIL ovf_main got wr=%0d end=%0d exp wr=6 end=1 status=%h", wr_q.size(), end_q.size(), exp_end_q[0]); end
  endtask

  task automatic test_random(input int iters);
    int m, toggle;
    for (int it = 0; it < iters; it++) begin
      clear_monitor();
      m = $urandom_range(0, 16);
      fill_random(m);
      if ($urandom_range(0, 1) == 1) append_fcs();
      toggle = (tx_q.size() > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4 * tx_q.size() - 2)) : -1;
      model_frame(1522);
      send_frame(toggle, $urandom_range(0, 2), 4);
      total++; if (wr_q.size() != exp_wr_q.size()) begin bad++; $display("[TB] FAIL rand%0d_wr_count got=%0d exp=%0d", it, wr_q.size(), exp_wr_q.size()); end
      foreach (exp_wr_q[i]) if (i < wr_q.size()) begin total++; if (wr_q[i] !== exp_wr_q[i]) begin bad++; $display("[TB] FAIL rand%0d_wr[%0d] got=%h exp=%h", it, i, wr_q[i], exp_wr_q[i]); end end
      total++; if (end_q.size() != 1 || end_q[0] !== exp_end_q[0]) begin bad++; $display("[TB] FAIL rand%0d_end got n=%0d first=%h exp n=1 first=%h", it, end_q.size(), (end_q.size() > 0) ? end_q[0] : 17'h0, exp_end_q[0]); end
      total++; if (overlap_cnt != 0) begin bad++; $display("[TB] FAIL rand%0d_overlap got=%0d exp=0", it, overlap_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    clear_monitor();
    fill_random($urandom_range(1, 8));
    append_fcs();
    model_frame(1522);
    send_frame(-1, 0, 0);
    fill_random($urandom_range(1, 8));
    model_frame(1522);
    send_frame(-1, 2, 4);
    total++; if (wr_q.size() != exp_wr_q.size()) begin bad++; $display("[TB] FAIL b2b_wr_count got=%0d exp=%0d", wr_q.size(), exp_wr_q.size()); end
    foreach (exp_wr_q[i]) if (i < wr_q.size()) begin total++; if (wr_q[i] !== exp_wr_q[i]) begin bad++; $display("[TB] FAIL b2b_wr[%0d] got=%h exp=%h", i, wr_q[i], exp_wr_q[i]); end end
    total++; if (end_q.size() != 2) begin bad++; $display("[TB] FAIL b2b_end_count got=%0d exp=2", end_q.size()); end
    foreach (exp_end_q[i]) if (i < end_q.size()) begin total++; if (end_q[i] !== exp_end_q[i]) begin bad++; $display("[TB] FAIL b2b_end[%0d] got=%h exp=%h", i, end_q[i], exp_end_q[i]); end end
  endtask

  task automatic test_fcs();
    logic [7:0] flipped;
    clear_monitor();
    fill_random(60);
    append_fcs();
    model_frame(1522);
    send_frame(-1, 0, 4);
    total++; if (end_q.size() != 1 || end_q[0] !== {1'b0, 16'd64}) begin bad++; $display("[TB] FAIL fcs_good got n=%0d first=%h exp n=1 err=0 len=64", end_q.size(), (end_q.size() > 0) ? end_q[0] : 17'h0); end
    total++; if (wr_q.size() != 64) begin bad++; $display("[TB] FAIL fcs_good_wr_count got=%0d exp=64", wr_q.size()); end
    clear_monitor();
    flipped = tx_q[17] ^ (8'h1 << $urandom_range(0, 7));
    tx_q[17] = flipped;
    model_frame(1522);
    send_frame(-1, 0, 4);
    total++; if (end_q.size() != 1 || end_q[0] !== {FCS_EN, 16'd64} || exp_end_q[0] !== {FCS_EN, 16'd64}) begin bad++; $display("[TB] FAIL fcs_flip got n=%0d first=%h exp n=1 err=%b len=64", end_q.size(), (end_q.size() > 0) ? end_q[0] : 17'h0, FCS_EN); end
  endtask

  task automatic test_reset_midframe();
    clear_monitor();
    send_preamble();
    for (int i = 0; i < 10; i++) dibit(1'b1, 2'($urandom));
    @(negedge clk50);
    rst = 1'b1; crs_dv = 1'b0;
    repeat (2) @(negedge clk50);
    rst = 1'b0;
    repeat (3) dibit(1'b0, 2'b00);
    total++; if (end_q.size() != 0 || s_end_q.size() != 0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_abort got end=%0d/%0d busy=%b exp 0/0 busy=0", end_q.size(), s_end_q.size(), busy); end
    clear_monitor();
    fill_random(3);
    append_fcs();
    model_frame(1522);
    send_frame(-1, 0, 4);
    total++; if (wr_q.size() != exp_wr_q.size()) begin bad++; $display("[TB] FAIL midrst_wr_count got=%0d exp=%0d", wr_q.size(), exp_wr_q.size()); end
    foreach (exp_wr_q[i]) if (i < wr_q.size()) begin total++; if (wr_q[i] !== exp_wr_q[i]) begin bad++; $display("[TB] FAIL midrst_wr[%0d] got=%h exp=%h", i, wr_q[i], exp_wr_q[i]); end end
    total++; if (end_q.size() != 1 || end_q[0] !== exp_end_q[0]) begin bad++; $display("[TB] FAIL midrst_end got n=%0d first=%h exp n=1 first=%h", end_q.size(), (end_q.size() > 0) ? end_q[0] : 17'h0, exp_end_q[0]); end
  endtask

  initial begin
    test_reset();
    test_basic(-1, "basic");
    test_basic(5, "toggle");
    test_bad_preamble();
    test_overflow();
    test_random(12);
    test_back_to_back();
    test_fcs();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
